// File: rtl/ec_pkg.sv
// Shared definitions for the EC field-arithmetic blocks: default element types,
// the bn128 base prime, the FSM state type and limb-count helpers.
package ec_pkg;

  typedef logic [255:0] fe_t;
  typedef logic [63:0]  fe_arith_t;

  localparam fe_t BN128_P =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } addsub_state_e;

  function automatic int div_of(input int fe_bits, input int arith_bits);
    return fe_bits / arith_bits;
  endfunction

  function automatic int cnt_bits_of(input int div);
    return (div == 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Minimal valid/ready stream with data, control tag and end-of-frame marker.
interface if_axi_stream #(
  parameter int DAT_BITS = 512,
  parameter int CTL_BITS = 8
);
  logic                val;
  logic                rdy;
  logic                last;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport source (output val, last, dat, ctl, input rdy);
  modport sink   (input val, last, dat, ctl, output rdy);
endinterface

// File: rtl/limb_addsub.sv
// Combinational W-bit limb adder (SUB=0) or subtractor (SUB=1) with carry/borrow chain.
module limb_addsub #(
  parameter int W   = 64,
  parameter bit SUB = 1'b0
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] y_o,
  output logic         c_o
);
  logic [W:0] r;

  // For subtraction the extra MSB goes to 1 exactly when the result underflowed.
  always_comb begin
    if (SUB) r = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, c_i};
    else     r = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
  end

  assign y_o = r[W-1:0];
  assign c_o = r[W];
endmodule

// File: rtl/ec_fp_addsub_serial.sv
// Limb-serial (a+b) mod P or (a-b) mod P: collects DIV limbs, computes raw and
// P-corrected candidates in parallel, then emits the in-range one LSB first.
module ec_fp_addsub_serial
  import ec_pkg::*;
#(
  parameter type FE_TYPE       = fe_t,
  parameter type FE_TYPE_ARITH = fe_arith_t,
  parameter FE_TYPE P          = FE_TYPE'(BN128_P),
  parameter bit  MODE          = 1'b0,
  parameter int  CTL_BITS      = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  if_axi_stream.sink    i_if,
  if_axi_stream.source  o_if,
  output logic          o_err
);
  localparam int FE_BITS    = $bits(FE_TYPE);
  localparam int ARITH_BITS = $bits(FE_TYPE_ARITH);
  localparam int DIV        = div_of(FE_BITS, ARITH_BITS);
  localparam int CNT_BITS   = cnt_bits_of(DIV);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(DIV - 1);

  addsub_state_e         state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  pc_q, pc_d;
  logic                  cc_q, cc_d;
  logic                  rdy_q, rdy_d;
  logic                  err_q, err_d;
  logic                  sel_q, sel_d;
  logic [CTL_BITS-1:0]   ctl_q, ctl_d;

  logic [ARITH_BITS-1:0] prim_buf_q [DIV];
  logic [ARITH_BITS-1:0] corr_buf_q [DIV];

  logic [ARITH_BITS-1:0] a_limb, b_limb, p_limb, prim_y, corr_y;
  logic                  prim_c, corr_c, take, give, pick_corr;

  assign a_limb = i_if.dat[0 +: ARITH_BITS];
  assign b_limb = i_if.dat[FE_BITS +: ARITH_BITS];

  always_comb begin
    p_limb = '0;
    for (int i = 0; i < DIV; i++) begin
      if (cnt_q == CNT_BITS'(i)) p_limb = P[i*ARITH_BITS +: ARITH_BITS];
    end
  end

  // Primary op on the operands, then the opposite op against P on its result.
  limb_addsub #(.W(ARITH_BITS), .SUB(MODE)) u_prim (
    .a_i(a_limb), .b_i(b_limb), .c_i(pc_q), .y_o(prim_y), .c_o(prim_c)
  );

  limb_addsub #(.W(ARITH_BITS), .SUB(!MODE)) u_corr (
    .a_i(prim_y), .b_i(p_limb), .c_i(cc_q), .y_o(corr_y), .c_o(corr_c)
  );

  // Add: reduce when the sum overflowed or is >= P. Sub: wrap by P on underflow.
  assign pick_corr = MODE ? prim_c : (prim_c | ~corr_c);

  assign take = (state_q == COLLECT) && i_if.val && rdy_q;
  assign give = (state_q == EMIT) && o_if.rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    cc_d    = cc_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    sel_d   = sel_q;
    ctl_d   = ctl_q;
    case (state_q)
      COLLECT: begin
        rdy_d = 1'b1;
        if (take) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          pc_d  = prim_c;
          cc_d  = corr_c;
          if (cnt_q == '0)            ctl_d = i_if.ctl;
          else if (i_if.ctl != ctl_q) err_d = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            pc_d    = 1'b0;
            cc_d    = 1'b0;
            sel_d   = pick_corr;
            rdy_d   = 1'b0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (give) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            rdy_d   = 1'b1;
            state_d = COLLECT;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      pc_q    <= 1'b0;
      cc_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      ctl_q   <= ctl_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (take) begin
      prim_buf_q[cnt_q] <= prim_y;
      corr_buf_q[cnt_q] <= corr_y;
    end
  end

  // Outputs decode from registered state so they are stable under backpressure.
  always_comb begin
    o_if.val  = (state_q == EMIT);
    o_if.last = (state_q == EMIT) && (cnt_q == LAST_IDX);
    o_if.ctl  = (state_q == EMIT) ? ctl_q : '0;
    o_if.dat  = '0;
    if (state_q == EMIT)
      o_if.dat[ARITH_BITS-1:0] = sel_q ? corr_buf_q[cnt_q] : prim_buf_q[cnt_q];
  end

  assign i_if.rdy = rdy_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_ec_fp_addsub_serial.sv
// Directed bench: one adder and one subtractor instance on a 16-bit field
// (two 8-bit limbs, P = 0xFFF1) with hand-computed results.
module tb_ec_fp_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8)) in0 ();
  if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8)) out0 ();
  if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8)) in1 ();
  if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8)) out1 ();

  logic        ival [2];
  logic [31:0] idat [2];
  logic [7:0]  ictl [2];
  logic        ordy [2];
  logic        irdy [2];
  logic        oval [2];
  logic        olast[2];
  logic [31:0] odat [2];
  logic [7:0]  octl [2];
  logic        oerr [2];

  assign in0.val  = ival[0];
  assign in0.dat  = idat[0];
  assign in0.ctl  = ictl[0];
  assign in0.last = 1'b0;
  assign out0.rdy = ordy[0];
  assign irdy[0]  = in0.rdy;
  assign oval[0]  = out0.val;
  assign olast[0] = out0.last;
  assign odat[0]  = out0.dat;
  assign octl[0]  = out0.ctl;

  assign in1.val  = ival[1];
  assign in1.dat  = idat[1];
  assign in1.ctl  = ictl[1];
  assign in1.last = 1'b0;
  assign out1.rdy = ordy[1];
  assign irdy[1]  = in1.rdy;
  assign oval[1]  = out1.val;
  assign olast[1] = out1.last;
  assign odat[1]  = out1.dat;
  assign octl[1]  = out1.ctl;

  ec_fp_addsub_serial #(
    .FE_TYPE(logic [15:0]), .FE_TYPE_ARITH(logic [7:0]),
    .P(16'hFFF1), .MODE(1'b0), .CTL_BITS(8)
  ) u_add (
    .i_clk(clk), .i_rst_n(rst_n), .i_if(in0), .o_if(out0), .o_err(oerr[0])
  );

  ec_fp_addsub_serial #(
    .FE_TYPE(logic [15:0]), .FE_TYPE_ARITH(logic [7:0]),
    .P(16'hFFF1), .MODE(1'b1), .CTL_BITS(8)
  ) u_sub (
    .i_clk(clk), .i_rst_n(rst_n), .i_if(in1), .o_if(out1), .o_err(oerr[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input int m, input string tag);
    check({tag, " val"},  32'(oval[m]),  0);
    check({tag, " last"}, 32'(olast[m]), 0);
    check({tag, " dat"},  odat[m],       0);
    check({tag, " ctl"},  32'(octl[m]),  0);
    check({tag, " rdy"},  32'(irdy[m]),  0);
    check({tag, " err"},  32'(oerr[m]),  0);
  endtask

  // Junk in the unused dat bits must not affect the result.
  task automatic send_beat(input int m, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    ival[m] = 1'b1;
    idat[m] = {8'h5A, b, 8'hA5, a};
    ictl[m] = c;
    while (!irdy[m] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!irdy[m]) check("in_rdy_timeout", 32'(irdy[m]), 1);
    @(posedge clk);
    #1;
    ival[m] = 1'b0;
  endtask

  task automatic send_op(input int m, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] c0, input logic [7:0] c1, input string tag);
    send_beat(m, a[7:0], b[7:0], c0);
    send_beat(m, a[15:8], b[15:8], c1);
    check({tag, " latency"}, 32'(oval[m]), 1);
    check({tag, " rdy_low"}, 32'(irdy[m]), 0);
  endtask

  task automatic recv_op(input int m, input logic [15:0] exp, input logic [7:0] expctl,
                         input int bp, input string tag);
    logic [7:0]  r [2];
    logic [40:0] snap;
    int n;
    if (bp > 0) begin
      @(negedge clk);
      snap = {odat[m], octl[m], olast[m]};
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        ival[m] = i[0];
        ictl[m] = 8'hEE;
        check({tag, " bp_hold"}, snap[31:0] ^ {odat[m][23:0], octl[m], olast[m]}, 0);
        check({tag, " bp_inrdy"}, 32'(irdy[m]), 0);
      end
      @(negedge clk);
      ival[m] = 1'b0;
      check({tag, " bp_err"}, 32'(oerr[m]), 0);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      ordy[m] = 1'b1;
      n = 0;
      while (!oval[m] && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!oval[m]) check({tag, " out_val_timeout"}, 32'(oval[m]), 1);
      r[j] = odat[m][7:0];
      check({tag, " ctl"},   32'(octl[m]),  32'(expctl));
      check({tag, " last"},  32'(olast[m]), (j == 1) ? 1 : 0);
      check({tag, " upper"}, 32'(odat[m][31:8]), 0);
      @(posedge clk);
      #1;
    end
    ordy[m] = 1'b0;
    check({tag, " result"}, 32'({r[1], r[0]}), 32'(exp));
    check({tag, " done_val"}, 32'(oval[m]), 0);
    check({tag, " done_rdy"}, 32'(irdy[m]), 1);
  endtask

  task automatic run_op(input int m, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input logic [7:0] c, input string tag);
    send_op(m, a, b, c, c, tag);
    recv_op(m, exp, c, 0, tag);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      ival[m] = 1'b0;
      idat[m] = '0;
      ictl[m] = '0;
      ordy[m] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0, "rst_add");
    check_reset(1, "rst_sub");
    rst_n = 1'b1;
    #1;
    check("rdy_before_clk", 32'(irdy[0]), 0);
    @(posedge clk);
    #1;
    check("rdy_after_clk_add", 32'(irdy[0]), 1);
    check("rdy_after_clk_sub", 32'(irdy[1]), 1);

    run_op(1, 16'h0005, 16'h0007, 16'hFFEF, 8'd9, "sub_5_7");
    check("sub_err", 32'(oerr[1]), 0);
    run_op(1, 16'h0007, 16'h0005, 16'h0002, 8'd1, "sub_7_5");
    run_op(1, 16'h0000, 16'hFFF0, 16'h0001, 8'd2, "sub_0_fff0");
    run_op(1, 16'h8000, 16'h8000, 16'h0000, 8'd3, "sub_equal");

    run_op(0, 16'hFFF0, 16'h0005, 16'h0004, 8'd4, "add_reduce");
    run_op(0, 16'h1234, 16'h0001, 16'h1235, 8'd5, "add_plain");
    run_op(0, 16'hFFF0, 16'h0001, 16'h0000, 8'd6, "add_eq_p");
    run_op(0, 16'hFFF0, 16'hFFF0, 16'hFFEF, 8'd7, "add_carry");

    send_op(0, 16'h00FF, 16'h0001, 8'h2C, 8'h2C, "add_bp");
    recv_op(0, 16'h0100, 8'h2C, 5, "add_bp");

    send_op(0, 16'h0010, 16'h0020, 8'd3, 8'd4, "add_ctlmis");
    recv_op(0, 16'h0030, 8'd3, 0, "add_ctlmis");
    check("ctlmis_err", 32'(oerr[0]), 1);
    run_op(0, 16'h0001, 16'h0001, 16'h0002, 8'd8, "add_after_err");
    check("err_sticky", 32'(oerr[0]), 1);
    check("err_other_inst", 32'(oerr[1]), 0);

    send_beat(0, 8'hFF, 8'hFF, 8'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset(0, "midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(0, 16'h0002, 16'h0003, 16'h0005, 8'd1, "add_after_rst");
    check("err_cleared", 32'(oerr[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
